fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 158 +++++++++++++++
 tb/tb_fetch_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the IF/ID register.
// Latency: one cycle from imem_ack to instr_out; one instruction per cycle with single-cycle ack.
// Backpressure: stall holds the output buffer; one extra response parks in a skid entry and fetch pauses.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   stall               decode cannot accept the current instr_out
//   redirect/redirect_pc taken branch/jump and its target (highest priority)
//   imem_req/imem_addr  request to instruction memory (address held until ack)
//   imem_ack/imem_rdata response handshake and instruction word
//   instr_out/pcp1_out/instr_valid  output buffer towards decode (NOP when invalid)
module fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [7:0]  redirect_pc,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr_out,
    output logic [7:0]  pcp1_out,
    output logic        instr_valid
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  pc, pc_nxt;
    logic [7:0]  req_addr, req_addr_nxt;
    logic [15:0] instr_nxt;
    logic [7:0]  pcp1_nxt;
    logic        valid_nxt;
    logic [15:0] skid_instr, skid_instr_nxt;
    logic [7:0]  skid_pcp1, skid_pcp1_nxt;
    logic        skid_valid, skid_valid_nxt;

    logic        consumed;
    logic        buf_free;
    logic [7:0]  next_addr;

    assign consumed  = instr_valid & ~stall;
    assign buf_free  = ~instr_valid | consumed;
    assign next_addr = req_addr + 8'd1;

    assign imem_req  = (state == S_REQ) || (state == S_DRAIN);
    assign imem_addr = req_addr;

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        req_addr_nxt   = req_addr;
        instr_nxt      = instr_out;
        pcp1_nxt       = pcp1_out;
        valid_nxt      = instr_valid;
        skid_instr_nxt = skid_instr;
        skid_pcp1_nxt  = skid_pcp1;
        skid_valid_nxt = skid_valid;

        // A consumed word leaves the buffer as a NOP unless refilled below.
        if (consumed) begin
            instr_nxt = 16'h0000;
            pcp1_nxt  = 8'h00;
            valid_nxt = 1'b0;
        end

        if (redirect && (state != S_IDLE)) begin
            instr_nxt      = 16'h0000;
            pcp1_nxt       = 8'h00;
            valid_nxt      = 1'b0;
            skid_valid_nxt = 1'b0;
            pc_nxt         = redirect_pc;
            if (((state == S_REQ) || (state == S_DRAIN)) && !imem_ack) begin
                // Request in flight must keep its address; drop its response later.
                state_nxt = S_DRAIN;
            end else begin
                req_addr_nxt = redirect_pc;
                state_nxt    = S_REQ;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (redirect) begin
                        pc_nxt       = redirect_pc;
                        req_addr_nxt = redirect_pc;
                    end else begin
                        req_addr_nxt = pc;
                    end
                    state_nxt = S_REQ;
                end
                S_REQ: begin
                    if (imem_ack) begin
                        pc_nxt = next_addr;
                        if (buf_free) begin
                            instr_nxt    = imem_rdata;
                            pcp1_nxt     = next_addr;
                            valid_nxt    = 1'b1;
                            req_addr_nxt = next_addr;
                        end else begin
                            skid_instr_nxt = imem_rdata;
                            skid_pcp1_nxt  = next_addr;
                            skid_valid_nxt = 1'b1;
                            state_nxt      = S_HOLD;
                        end
                    end
                end
                S_DRAIN: begin
                    if (imem_ack) begin
                        req_addr_nxt = pc;
                        state_nxt    = S_REQ;
                    end
                end
                S_HOLD: begin
                    if (consumed) begin
                        instr_nxt      = skid_instr;
                        pcp1_nxt       = skid_pcp1;
                        valid_nxt      = skid_valid;
                        skid_valid_nxt = 1'b0;
                        req_addr_nxt   = pc;
                        state_nxt      = S_REQ;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= 8'h00;
            req_addr    <= 8'h00;
            instr_out   <= 16'h0000;
            pcp1_out    <= 8'h00;
            instr_valid <= 1'b0;
            skid_instr  <= 16'h0000;
            skid_pcp1   <= 8'h00;
            skid_valid  <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            req_addr    <= req_addr_nxt;
            instr_out   <= instr_nxt;
            pcp1_out    <= pcp1_nxt;
            instr_valid <= valid_nxt;
            skid_instr  <= skid_instr_nxt;
            skid_pcp1   <= skid_pcp1_nxt;
            skid_valid  <= skid_valid_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios followed by random traffic for fetch_unit.
// Memory returns 16'h1000 + address; expected stream is the address sequence restarted by redirects.
// Outputs sampled 1 time unit after the rising edge; inputs driven at the same point.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr_out;
    logic [7:0]  pcp1_out;
    logic        instr_valid;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .pcp1_out    (pcp1_out),
        .instr_valid (instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_cons = 0;

    // Reference model: address of the next instruction decode should receive.
    logic [7:0]  exp_addr;
    logic        prev_hold, prev_rd, prev_frz;
    logic [7:0]  prev_addr;
    logic [15:0] frz_instr;
    logic [7:0]  frz_pcp1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset(input logic ak, input logic rd);
        rst         = 1'b1;
        stall       = 1'($urandom);
        redirect    = rd;
        redirect_pc = 8'($urandom);
        imem_ack    = ak;
        imem_rdata  = 16'($urandom);
        @(posedge clk);
        #1;
        chk("rst_instr", instr_out, 0);
        chk("rst_pcp1", pcp1_out, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        rst       = 1'b0;
        redirect  = 1'b0;
        imem_ack  = 1'b0;
        exp_addr  = 8'h00;
        prev_hold = 1'b0;
        prev_rd   = 1'b0;
        prev_frz  = 1'b0;
    endtask

    // One clock cycle: apply inputs, check the visible state against the model, advance.
    task automatic cycle(input logic st, input logic rd, input logic [7:0] rpc, input logic ak);
        logic [15:0] exp_instr;
        logic [7:0]  exp_pcp1;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem_ack    = ak;
        imem_rdata  = (ak && imem_req) ? (16'h1000 + {8'h00, imem_addr}) : 16'($urandom);

        if (prev_hold) begin
            chk("addr_stable_req", imem_req, 1);
            chk("addr_stable", imem_addr, prev_addr);
        end
        if (prev_rd) chk("squash_after_redirect", instr_valid, 0);
        if (prev_frz) begin
            chk("stall_hold_valid", instr_valid, 1);
            chk("stall_hold_instr", instr_out, frz_instr);
            chk("stall_hold_pcp1", pcp1_out, frz_pcp1);
        end
        if (!instr_valid) begin
            chk("nop_when_invalid", {instr_out, pcp1_out}, 0);
        end else if (!st) begin
            exp_instr = 16'h1000 + {8'h00, exp_addr};
            exp_pcp1  = exp_addr + 8'd1;
            chk("stream_instr", instr_out, exp_instr);
            chk("stream_pcp1", pcp1_out, exp_pcp1);
            exp_addr = exp_pcp1;
            n_cons++;
        end
        if (rd) exp_addr = rpc;

        prev_hold = imem_req && !ak;
        prev_addr = imem_addr;
        prev_rd   = rd;
        prev_frz  = instr_valid && st && !rd;
        frz_instr = instr_out;
        frz_pcp1  = pcp1_out;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
        imem_ack = 1'b0; imem_rdata = 16'h0000;
        exp_addr = 8'h00; prev_hold = 1'b0; prev_rd = 1'b0; prev_frz = 1'b0;
        prev_addr = 8'h00; frz_instr = 16'h0000; frz_pcp1 = 8'h00;
        @(posedge clk);
        #1;

        // Streaming from reset with ack tied high; reset overrides redirect/ack.
        do_reset(1'b1, 1'b1);
        cycle(0, 0, 8'h00, 1);
        chk("s_req_cycle1", imem_req, 1);
        chk("s_addr_cycle1", imem_addr, 8'h00);
        cycle(0, 0, 8'h00, 1);
        chk("s_instr0", instr_out, 16'h1000);
        chk("s_pcp1_0", pcp1_out, 8'h01);
        cycle(0, 0, 8'h00, 1);
        chk("s_instr1", instr_out, 16'h1001);
        chk("s_pcp1_1", pcp1_out, 8'h02);
        cycle(0, 0, 8'h00, 1);
        chk("s_instr2", instr_out, 16'h1002);
        chk("s_pcp1_2", pcp1_out, 8'h03);

        // Stall three cycles: one word parks in the skid, fetch pauses.
        cycle(1, 0, 8'h00, 1);
        chk("hold_req0", imem_req, 0);
        chk("hold_instr", instr_out, 16'h1002);
        cycle(1, 0, 8'h00, 1);
        chk("hold_req1", imem_req, 0);
        cycle(1, 0, 8'h00, 1);
        chk("hold_req2", imem_req, 0);
        cycle(0, 0, 8'h00, 1);
        chk("skid_out_instr", instr_out, 16'h1003);
        chk("skid_out_valid", instr_valid, 1);
        cycle(0, 0, 8'h00, 1);
        chk("after_skid_instr", instr_out, 16'h1004);

        // Redirect while a request waits for its ack.
        do_reset(1'b0, 1'b0);
        cycle(0, 1, 8'h05, 0);
        chk("d_addr5", imem_addr, 8'h05);
        cycle(0, 0, 8'h00, 0);
        cycle(0, 1, 8'h40, 0);
        chk("d_drain_req", imem_req, 1);
        chk("d_drain_addr", imem_addr, 8'h05);
        cycle(0, 0, 8'h00, 0);
        chk("d_drain_addr2", imem_addr, 8'h05);
        cycle(0, 0, 8'h00, 1);
        chk("d_new_addr", imem_addr, 8'h40);
        chk("d_discarded", instr_valid, 0);
        cycle(0, 0, 8'h00, 1);
        chk("d_valid", instr_valid, 1);
        chk("d_pcp1", pcp1_out, 8'h41);

        // Redirect coincident with ack.
        do_reset(1'b0, 1'b0);
        cycle(0, 1, 8'h10, 0);
        chk("c_addr10", imem_addr, 8'h10);
        cycle(0, 1, 8'h40, 1);
        chk("c_squash", instr_valid, 0);
        chk("c_addr40", imem_addr, 8'h40);
        cycle(0, 0, 8'h00, 1);
        chk("c_instr", instr_out, 16'h1040);
        chk("c_pcp1", pcp1_out, 8'h41);

        // Wrap at address FF.
        cycle(0, 1, 8'hFF, 1);
        chk("w_addr_ff", imem_addr, 8'hFF);
        cycle(0, 0, 8'h00, 1);
        chk("w_instr", instr_out, 16'h10FF);
        chk("w_pcp1", pcp1_out, 8'h00);
        chk("w_next_addr", imem_addr, 8'h00);
        cycle(0, 0, 8'h00, 1);
        chk("w_instr_next", instr_out, 16'h1000);

        // Reset while draining after a skid-full hold.
        cycle(1, 0, 8'h00, 1);
        cycle(1, 1, 8'h80, 0);
        cycle(1, 1, 8'h90, 0);
        chk("r_drain_addr", imem_addr, 8'h80);
        do_reset(1'b1, 1'b1);
        cycle(0, 0, 8'h00, 1);
        chk("r_resume_addr", imem_addr, 8'h00);
        cycle(0, 0, 8'h00, 1);
        chk("r_resume_instr", instr_out, 16'h1000);

        // Random traffic against the stream model.
        n_cons = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0)
                do_reset(1'($urandom), 1'($urandom));
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                  8'($urandom), $urandom_range(0, 2) != 0);
        end
        chk("liveness", (n_cons > 300), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
